// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Phase-1 CPU control unit: sequencer states,
// instruction classes, ALU opcodes and IR field positions.
package cpu_ctrl_pkg;

    // Control steps: fetch T0-T2, execute T3-T6, plus reset and halt.
    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    // Execute-sequence families; every recognised opcode maps to exactly one.
    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_REG3,
        CLS_MULDIV,
        CLS_UNARY
    } instr_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Map an opcode to the execute sequence it needs; anything unknown is a NOP.
    function automatic instr_class_t decode_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      return CLS_REG3;
            OP_MUL, OP_DIV:                       return CLS_MULDIV;
            OP_NEG, OP_NOT:                       return CLS_UNARY;
            default:                              return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-to-16 one-hot decoder with enable, used for the GPR read and write selects.
module reg_onehot_dec (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    // At most one bit set, and none at all when the select is disabled.
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer driving the DataPath register-transfer strobes.
// Optional feature macro: MEM_WAIT_EN -- T1 stretches until mem_ready is high.
// Outputs are a Moore decode of the state register (and the IR fields during
// execute), so forcing the state to RST on clear zeroes them immediately.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        stop,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        IRin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t       state;
    instr_class_t cls;
    logic [4:0]   op;
    logic [3:0]   ra, rb, rc;
    logic [3:0]   rin_idx, rout_idx;
    logic         rin_en, rout_en;
    logic         unused_inputs;

    assign op  = ir[OP_MSB:OP_LSB];
    assign ra  = ir[RA_MSB:RA_LSB];
    assign rb  = ir[RB_MSB:RB_LSB];
    assign rc  = ir[RC_MSB:RC_LSB];
    assign cls = decode_class(op);

    // Low IR bits carry operands this unit never decodes; mem_ready is only
    // consulted when the wait-state feature is built in.
    assign unused_inputs = ^{ir[RC_LSB-1:0], mem_ready};

    // State register: one step per cycle; stop is sampled on each
    // instruction's final step. The T2 branch reads ir, so the IR word must
    // already be visible on ir by the end of T2.
    always_ff @(posedge clock or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (clear) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST: state <= ST_T0;
                ST_T0:  state <= ST_T1;
`ifdef MEM_WAIT_EN
                ST_T1:  state <= mem_ready ? ST_T2 : ST_T1;
`else
                ST_T1:  state <= ST_T2;
`endif
                ST_T2: begin
                    if (cls == CLS_NOP) state <= stop ? ST_HALT : ST_T0;
                    else                state <= ST_T3;
                end
                ST_T3:  state <= ST_T4;
                ST_T4: begin
                    if (cls == CLS_UNARY) state <= stop ? ST_HALT : ST_T0;
                    else                  state <= ST_T5;
                end
                ST_T5: begin
                    if (cls == CLS_MULDIV) state <= ST_T6;
                    else                   state <= stop ? ST_HALT : ST_T0;
                end
                ST_T6:   state <= stop ? ST_HALT : ST_T0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Strobe decode for the current step; everything defaults to inactive.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = 5'b00000;
        rin_en   = 1'b0;
        rin_idx  = 4'd0;
        rout_en  = 1'b0;
        rout_idx = 4'd0;
        run      = (state != ST_RST) && (state != ST_HALT);

        case (state)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                alu_op = OP_ADD;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
`ifdef MEM_WAIT_EN
                // PC reloads only in the completing cycle of the read.
                PCin    = mem_ready;
                Zlowout = mem_ready;
`else
                PCin    = 1'b1;
                Zlowout = 1'b1;
`endif
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_REG3: begin
                        rout_en = 1'b1; rout_idx = rb; Yin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1; rout_idx = ra; Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en = 1'b1; rout_idx = rb; Zin = 1'b1; alu_op = op;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_REG3: begin
                        rout_en = 1'b1; rout_idx = rc; Zin = 1'b1; alu_op = op;
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1; rout_idx = rb; Zin = 1'b1; alu_op = op;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1; rin_en = 1'b1; rin_idx = ra;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_REG3: begin
                        Zlowout = 1'b1; rin_en = 1'b1; rin_idx = ra;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (cls == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_onehot_dec u_rin_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_onehot_dec u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus branch pushes the
// expected output word for each cycle it drives, the monitor branch pops and
// compares on every falling edge. Build with MEM_WAIT_EN to add the
// wait-state sequence.
module tb_control_sequencer;

    typedef struct packed {
        logic        run;
        logic        pc_out, mar_in, inc_pc, pc_in, ir_in, read, mdr_in;
        logic        mdr_out, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu_op;
    } outs_t;

    // Execute-step flag bits for o_ex: {Yin, Zin, Zlowout, Zhighout, LOin, HIin}
    localparam logic [5:0] F_Y  = 6'b100000;
    localparam logic [5:0] F_Z  = 6'b010000;
    localparam logic [5:0] F_ZL = 6'b001000;
    localparam logic [5:0] F_ZH = 6'b000100;
    localparam logic [5:0] F_LO = 6'b000010;
    localparam logic [5:0] F_HI = 6'b000001;

    localparam logic [31:0] IR_AND = 32'h2A2B8000;  // AND R4,R5,R7
    localparam logic [31:0] IR_MUL = 32'h79300000;  // MUL R2,R6
    localparam logic [31:0] IR_NOT = 32'h90900000;  // NOT R1,R2
    localparam logic [31:0] IR_NOP = 32'hF8000000;  // op 11111
    localparam logic [31:0] IR_ADD = 32'h18918000;  // ADD R1,R2,R3

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        stop;
    logic        mem_ready;
    logic        PCout, MARin, IncPC, PCin, IRin, Read, MDRin, MDRout;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        run;
    outs_t       act;

    outs_t       exp_q[$];
    string       tag_q[$];
    int          n_checks;
    int          n_fail;
    bit          stim_done;

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .ir        (ir),
        .stop      (stop),
        .mem_ready (mem_ready),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .PCin      (PCin),
        .IRin      (IRin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .Yin       (Yin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rin       (Rin),
        .Rout      (Rout),
        .alu_op    (alu_op),
        .run       (run)
    );

    assign act = {run, PCout, MARin, IncPC, PCin, IRin, Read, MDRin,
                  MDRout, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                  Rin, Rout, alu_op};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic outs_t o_zero();
        return '0;
    endfunction

    function automatic outs_t o_t0();
        outs_t o = '0;
        o.run = 1'b1; o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1;
        o.z_in = 1'b1; o.alu_op = 5'b00011;
        return o;
    endfunction

    function automatic outs_t o_t1(input bit last);
        outs_t o = '0;
        o.run = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
        o.pc_in = last; o.zlow_out = last;
        return o;
    endfunction

    function automatic outs_t o_t2();
        outs_t o = '0;
        o.run = 1'b1; o.mdr_out = 1'b1; o.ir_in = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_ex(input logic [15:0] rout, input logic [15:0] rin,
                                   input logic [4:0] alu, input logic [5:0] f);
        outs_t o = '0;
        o.run = 1'b1;
        o.rout = rout; o.rin = rin; o.alu_op = alu;
        o.y_in = f[5]; o.z_in = f[4]; o.zlow_out = f[3];
        o.zhigh_out = f[2]; o.lo_in = f[1]; o.hi_in = f[0];
        return o;
    endfunction

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input outs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check(input outs_t got, input outs_t e, input string tag);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, e);
        end
    endtask

    // T0..T2 with the new IR word and stop level presented from T0 onwards.
    task automatic fetch(input logic [31:0] ir_val, input logic stop_val, input string tag);
        next_cycle();
        ir = ir_val;
        stop = stop_val;
        expect_out(o_t0(), {tag, "_t0"});
        next_cycle();
        expect_out(o_t1(1'b1), {tag, "_t1"});
        next_cycle();
        expect_out(o_t2(), {tag, "_t2"});
    endtask

    initial begin
        clear = 1'b1;
        ir = '0;
        stop = 1'b0;
        mem_ready = 1'b1;
        n_checks = 0;
        n_fail = 0;
        stim_done = 1'b0;

        fork
            begin : stimulus
                next_cycle(); expect_out(o_zero(), "clear_a");
                next_cycle(); expect_out(o_zero(), "clear_b");
                next_cycle(); clear = 1'b0; expect_out(o_zero(), "rst");

                fetch(IR_AND, 1'b0, "and");
                next_cycle(); expect_out(o_ex(16'h0020, 16'h0000, 5'b00000, F_Y),        "and_t3");
                next_cycle(); expect_out(o_ex(16'h0080, 16'h0000, 5'b00101, F_Z),        "and_t4");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0010, 5'b00000, F_ZL),       "and_t5");

                fetch(IR_MUL, 1'b0, "mul");
                next_cycle(); expect_out(o_ex(16'h0004, 16'h0000, 5'b00000, F_Y),        "mul_t3");
                next_cycle(); expect_out(o_ex(16'h0040, 16'h0000, 5'b01111, F_Z),        "mul_t4");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0000, 5'b00000, F_ZL | F_LO), "mul_t5");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0000, 5'b00000, F_ZH | F_HI), "mul_t6");

                fetch(IR_NOT, 1'b0, "not");
                next_cycle(); expect_out(o_ex(16'h0004, 16'h0000, 5'b10010, F_Z),        "not_t3");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0002, 5'b00000, F_ZL),       "not_t4");

                // Unknown opcode: the following fetch's T0 must come right after T2.
                fetch(IR_NOP, 1'b0, "nop");

`ifdef MEM_WAIT_EN
                next_cycle(); ir = IR_NOP; mem_ready = 1'b0; expect_out(o_t0(), "wait_t0");
                next_cycle(); expect_out(o_t1(1'b0), "wait_t1_a");
                next_cycle(); expect_out(o_t1(1'b0), "wait_t1_b");
                next_cycle(); expect_out(o_t1(1'b0), "wait_t1_c");
                next_cycle(); mem_ready = 1'b1; expect_out(o_t1(1'b1), "wait_t1_last");
                next_cycle(); expect_out(o_t2(), "wait_t2");
`endif

                // Halt request on the last execute step of an ADD.
                fetch(IR_ADD, 1'b1, "add");
                next_cycle(); expect_out(o_ex(16'h0004, 16'h0000, 5'b00000, F_Y),        "add_t3");
                next_cycle(); expect_out(o_ex(16'h0008, 16'h0000, 5'b00011, F_Z),        "add_t4");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0002, 5'b00000, F_ZL),       "add_t5");
                for (int i = 0; i < 4; i++) begin
                    next_cycle(); expect_out(o_zero(), "halt");
                end
                next_cycle(); clear = 1'b1; stop = 1'b0; expect_out(o_zero(), "halt_clear");
                next_cycle(); clear = 1'b0; expect_out(o_zero(), "halt_rst");

                // Restart, then clear arrives in the middle of T4.
                fetch(IR_AND, 1'b0, "and2");
                next_cycle(); expect_out(o_ex(16'h0020, 16'h0000, 5'b00000, F_Y),        "and2_t3");
                next_cycle();
                check(act, o_ex(16'h0080, 16'h0000, 5'b00101, F_Z), "and2_t4_pre");
                #1 clear = 1'b1;
                #1 check(act, o_zero(), "clear_async");
                expect_out(o_zero(), "clear_hold");
                next_cycle(); clear = 1'b0; expect_out(o_zero(), "rst2");

                fetch(IR_NOT, 1'b0, "not2");
                next_cycle(); expect_out(o_ex(16'h0004, 16'h0000, 5'b10010, F_Z),        "not2_t3");
                next_cycle(); expect_out(o_ex(16'h0000, 16'h0002, 5'b00000, F_ZL),       "not2_t4");
                next_cycle(); expect_out(o_t0(), "not2_next_t0");
                stim_done = 1'b1;
            end
            begin : monitor
                outs_t e;
                string t;
                while (!stim_done || exp_q.size() > 0) begin
                    @(negedge clock);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        t = tag_q.pop_front();
                        check(act, e, t);
                    end
                end
            end
        join

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
